// File: rtl/arm_mem_responder_pkg.sv
// arm_mem_responder_pkg: shared bus encodings (transfer sizes, FSM state codes) for the ARM7 memory responder.
package arm_mem_responder_pkg;
  localparam logic [1:0] MAS_BYTE = 2'b00;
  localparam logic [1:0] MAS_HALF = 2'b01;
  localparam logic [1:0] MAS_WORD = 2'b10;
  localparam logic [1:0] MAS_RSVD = 2'b11;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/arm_mem_lane.sv
// arm_mem_lane: byte enables and lane-replicated read data from transfer size and low address bits.
module arm_mem_lane
  import arm_mem_responder_pkg::*;
(
  input  logic [1:0]  mas,
  input  logic [1:0]  a,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{a, 3'b000} +: 8];
    h = a[1] ? rdata[31:16] : rdata[15:0];
    be = (mas == MAS_BYTE) ? 4'b0001 << a :
         (mas == MAS_HALF) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    lane_data = (mas == MAS_BYTE) ? {4{b}} :
                (mas == MAS_HALF) ? {2{h}} : rdata;
  end
endmodule

// File: rtl/arm_mem_responder.sv
// arm_mem_responder: ARM7 bus memory slave bridging core address/data phases to a req/ack backend.
// Optional range/size abort checking is enabled by defining ABORT_CHECK_EN.
module arm_mem_responder
  import arm_mem_responder_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 16,
  parameter int MEM_BYTES   = 65536
) (
  input  logic              sysclk,
  input  logic              RESET,
  input  logic              nMREQ,
  input  logic              nRW,
  input  logic [1:0]        MAS,
  input  logic [31:0]       A_MAR,
  input  logic [31:0]       D_in,
  output logic [31:0]       D_out,
  output logic              D_oe,
  output logic              nWAIT,
  output logic              ABORT,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);
`ifdef ABORT_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif
  state_t      state, state_nx;
  logic [1:0]  mas_q, lo_q;
  logic        wr_q, abort_q, ack_seen, first_q;
  logic [3:0]  cnt;
  logic [31:0] rdata_q, lane_data;
  logic [3:0]  lane_be;
  logic        capture, bad, ack_hit, done_go;
  arm_mem_lane u_lane (
    .mas       (mas_q),
    .a         (lo_q),
    .rdata     (rdata_q),
    .be        (lane_be),
    .lane_data (lane_data)
  );
  assign capture = (state != ST_BUSY) & ~nMREQ;
  assign bad     = CHECK & (({1'b0, A_MAR} >= 33'(MEM_BYTES)) | (MAS == MAS_RSVD));
  assign ack_hit = mem_ack & mem_req;
  assign done_go = (ack_seen | ack_hit) & (cnt == 4'd0);
  always_ff @(posedge sysclk) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    state_nx = (state == ST_BUSY) ? (done_go ? ST_DONE : ST_BUSY) :
               capture ? (bad ? ST_DONE : ST_BUSY) : ST_IDLE;
  end
  // Aborted accesses never raise mem_req, so the backend sees nothing.
  always_ff @(posedge sysclk) begin
    if (RESET) begin
      mas_q     <= '0;
      lo_q      <= '0;
      wr_q      <= 1'b0;
      abort_q   <= 1'b0;
      ack_seen  <= 1'b0;
      first_q   <= 1'b0;
      cnt       <= '0;
      rdata_q   <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (capture) begin
      mas_q    <= MAS;
      lo_q     <= A_MAR[1:0];
      wr_q     <= nRW;
      abort_q  <= bad;
      ack_seen <= 1'b0;
      first_q  <= ~bad;
      cnt      <= 4'(WAIT_STATES);
      mem_req  <= ~bad;
      mem_addr <= A_MAR[ADDR_W+1:2];
    end else if (state == ST_BUSY) begin
      cnt     <= (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
      first_q <= 1'b0;
      if (first_q) mem_wdata <= D_in;
      if (ack_hit) begin
        rdata_q  <= mem_rdata;
        ack_seen <= 1'b1;
        mem_req  <= 1'b0;
      end
    end
  end
  always_comb begin
    nWAIT  = state != ST_BUSY;
    D_oe   = (state == ST_DONE) & ~wr_q & ~abort_q;
    D_out  = D_oe ? lane_data : 32'd0;
    ABORT  = (state == ST_DONE) & abort_q;
    mem_we = mem_req & wr_q;
    mem_be = mem_req ? lane_be : 4'b0000;
  end
endmodule

// File: tb/tb_arm_mem_responder.sv
// tb_arm_mem_responder: directed scoreboard bench for arm_mem_responder with WAIT_STATES 0 and 3 instances.
module tb_arm_mem_responder;
  typedef struct {
    logic [31:0] dout;
    logic [3:0]  be;
    logic [15:0] maddr;
    logic        we;
    logic [31:0] wdata;
    int          lows;
  } exp_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic        nmreq0 = 1'b1, nmreq3 = 1'b1, nrw = 1'b0, ack0 = 1'b0, ack3 = 1'b0;
  logic [1:0]  mas = 2'b10;
  logic [31:0] addr = '0, din = '0, rdata = '0;
  logic [31:0] dout0, dout3, wdata0, wdata3;
  logic        doe0, doe3, nw0, nw3, ab0, ab3, req0, req3, we0, we3;
  logic [15:0] ma0, ma3;
  logic [3:0]  be0, be3;
  logic        sel = 1'b0;
  logic [31:0] o_dout, o_wdata;
  logic        o_doe, o_nwait, o_abort, o_req, o_we;
  logic [15:0] o_addr;
  logic [3:0]  o_be;
  int          errors = 0, checks = 0;
  exp_t        sb[$];
  exp_t        e;
  logic [31:0] cur_rd;
  int          cur_ad;
  always #5 clk = ~clk;
  arm_mem_responder #(.WAIT_STATES(0)) dut0 (
    .sysclk(clk), .RESET(rst), .nMREQ(nmreq0), .nRW(nrw), .MAS(mas), .A_MAR(addr),
    .D_in(din), .D_out(dout0), .D_oe(doe0), .nWAIT(nw0), .ABORT(ab0), .mem_req(req0),
    .mem_we(we0), .mem_addr(ma0), .mem_be(be0), .mem_wdata(wdata0), .mem_rdata(rdata),
    .mem_ack(ack0));
  arm_mem_responder #(.WAIT_STATES(3)) dut3 (
    .sysclk(clk), .RESET(rst), .nMREQ(nmreq3), .nRW(nrw), .MAS(mas), .A_MAR(addr),
    .D_in(din), .D_out(dout3), .D_oe(doe3), .nWAIT(nw3), .ABORT(ab3), .mem_req(req3),
    .mem_we(we3), .mem_addr(ma3), .mem_be(be3), .mem_wdata(wdata3), .mem_rdata(rdata),
    .mem_ack(ack3));
  assign o_dout  = sel ? dout3 : dout0;
  assign o_wdata = sel ? wdata3 : wdata0;
  assign o_doe   = sel ? doe3 : doe0;
  assign o_nwait = sel ? nw3 : nw0;
  assign o_abort = sel ? ab3 : ab0;
  assign o_req   = sel ? req3 : req0;
  assign o_we    = sel ? we3 : we0;
  assign o_addr  = sel ? ma3 : ma0;
  assign o_be    = sel ? be3 : be0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic issue(input bit s, input logic w, input logic [1:0] m, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int ad);
    exp_t x;
    int ws;
    ws = s ? 3 : 0;
    sel = s; nrw = w; mas = m; addr = a; din = wd; cur_rd = rd; cur_ad = ad;
    if (m == 2'b00) begin
      x.be = 4'b0001 << a[1:0];
      x.dout = ((rd >> (8 * a[1:0])) & 32'h0000_00FF) * 32'h0101_0101;
    end else if (m == 2'b01) begin
      x.be = a[1] ? 4'b1100 : 4'b0011;
      x.dout = ((rd >> (a[1] ? 16 : 0)) & 32'h0000_FFFF) * 32'h0001_0001;
    end else begin
      x.be = 4'b1111;
      x.dout = rd;
    end
    x.maddr = a[17:2];
    x.we = w;
    x.wdata = wd;
    x.lows = 1 + ((ws > ad) ? ws : ad);
    sb.push_back(x);
    if (s) nmreq3 = 1'b0; else nmreq0 = 1'b0;
  endtask
  task automatic run();
    int lows;
    bit done, got;
    lows = 0; done = 0; got = 0;
    @(posedge clk); #1 nmreq0 = 1'b1; nmreq3 = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!got) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 32'd0, 32'd1);
          return;
        end
        e = sb.pop_front();
        got = 1;
      end
      if (o_nwait) done = 1;
      else begin
        if (k == 0) begin
          chk("busy_req", o_req, 1'b1);
          chk("busy_be", o_be, e.be);
          chk("busy_addr", o_addr, e.maddr);
          chk("busy_we", o_we, e.we);
        end
        rdata = cur_rd;
        if (sel) ack3 = (k == cur_ad); else ack0 = (k == cur_ad);
        lows++;
        @(posedge clk); #1 ack0 = 1'b0; ack3 = 1'b0;
      end
    end
    if (!done) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    chk("nwait_low_cycles", lows, e.lows);
    chk("done_abort", o_abort, 1'b0);
    chk("done_req", o_req, 1'b0);
    chk("done_doe", o_doe, !e.we);
    if (e.we) chk("done_wdata", o_wdata, e.wdata);
    else      chk("done_dout", o_dout, e.dout);
  endtask
  task automatic idle();
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_nwait", o_nwait, 1'b1);
      chk("rst_doe", o_doe, 1'b0);
      chk("rst_dout", o_dout, 32'd0);
      chk("rst_abort", o_abort, 1'b0);
      chk("rst_req", o_req, 1'b0);
      chk("rst_we", o_we, 1'b0);
      chk("rst_be", o_be, 4'b0000);
      chk("rst_addr", o_addr, 16'd0);
      chk("rst_wdata", o_wdata, 32'd0);
    end
    issue(0, 1'b0, 2'b10, 32'h100, 32'h0, 32'hDEADBEEF, 0); run(); idle();
    issue(0, 1'b0, 2'b00, 32'h103, 32'h0, 32'h11223344, 0); run(); idle();
    issue(0, 1'b1, 2'b01, 32'h202, 32'hABCDABCD, 32'h0, 0); run(); idle();
    issue(0, 1'b0, 2'b00, 32'h101, 32'h0, 32'h11223344, 1); run(); idle();
    issue(0, 1'b0, 2'b01, 32'h102, 32'h0, 32'hCAFEF00D, 2); run();
    issue(0, 1'b0, 2'b10, 32'h407, 32'h0, 32'h0BADF00D, 1); run(); idle();
    issue(1, 1'b0, 2'b10, 32'h10, 32'h0, 32'h12345678, 0); run(); idle();
    issue(1, 1'b1, 2'b00, 32'h21, 32'h5A5A5A5A, 32'h0, 6); run(); idle();
    issue(1, 1'b0, 2'b01, 32'h30, 32'h0, 32'h89ABCDEF, 2); run(); idle();
    sel = 1'b0; nrw = 1'b0; mas = 2'b10; addr = 32'h300; nmreq0 = 1'b0;
    @(posedge clk); #1 nmreq0 = 1'b1;
    @(negedge clk);
    chk("rstbusy_nwait_pre", o_nwait, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstbusy_nwait", o_nwait, 1'b1);
    chk("rstbusy_req", o_req, 1'b0);
    rdata = 32'hFFFF_FFFF; ack0 = 1'b1;
    @(posedge clk); #1 ack0 = 1'b0;
    @(negedge clk);
    chk("late_ack_nwait", o_nwait, 1'b1);
    chk("late_ack_req", o_req, 1'b0);
    chk("late_ack_doe", o_doe, 1'b0);
`ifdef ABORT_CHECK_EN
    sel = 1'b0; nrw = 1'b0; mas = 2'b10; addr = 32'h10000; nmreq0 = 1'b0;
    @(posedge clk); #1 nmreq0 = 1'b1;
    @(negedge clk);
    chk("abort_flag", o_abort, 1'b1);
    chk("abort_req", o_req, 1'b0);
    chk("abort_nwait", o_nwait, 1'b1);
    chk("abort_doe", o_doe, 1'b0);
    chk("abort_dout", o_dout, 32'd0);
    @(negedge clk);
    chk("abort_clear", o_abort, 1'b0);
    chk("abort_req_after", o_req, 1'b0);
`else
    @(posedge clk); #1;
    issue(0, 1'b0, 2'b11, 32'h10006, 32'h0, 32'h76543210, 0); run(); idle();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
